// File: rtl/lfsr_word_packer.sv
// Packs LFSR output chunks into words, buffers them in a FWFT FIFO, and
// throttles the LFSR enable so no generated chunk is ever lost.
module lfsr_word_packer #(
    parameter int unsigned IN_BITS    = 1,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          run,
    output logic                          lfsr_enable,
    input  logic [IN_BITS-1:0]            lfsr_bits,
    input  logic                          lfsr_valid,
    output logic [WORD_WIDTH-1:0]         word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   word_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int unsigned CHUNKS = WORD_WIDTH / IN_BITS;
    localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    logic                  r_run_q;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_pack;
    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [15:0]           r_word_count;
    logic                  r_overflow;

    logic [WORD_WIDTH-1:0] w_word;
    logic [31:0]           w_base;
    logic [LVL_W-1:0]      w_free;
    logic                  w_last;
    logic                  w_full;
    logic                  w_complete;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Pack register with the current chunk merged in at its slot
    assign w_base = 32'(r_idx) * IN_BITS;
    always_comb begin
        w_word                     = r_pack;
        w_word[w_base +: IN_BITS]  = lfsr_bits;
    end

    assign w_last     = (r_idx == IDX_W'(CHUNKS - 1));
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_complete = lfsr_valid && w_last;
    assign w_pop      = word_valid && word_ready;
    assign w_push     = w_complete && (!w_full || w_pop);
    assign w_drop     = w_complete && w_full && !w_pop;

    // Two free entries: the word finishing now plus the chunk already requested
    assign w_free      = LVL_W'(FIFO_DEPTH) - r_level;
    assign lfsr_enable = r_run_q && (w_free >= LVL_W'(2));

    assign word_valid = (r_level != '0);
    assign word_data  = r_mem[r_rd_ptr];
    assign fifo_level = r_level;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_q      <= 1'b0;
            r_idx        <= '0;
            r_pack       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_run_q <= run;

            if (lfsr_valid) begin
                r_pack <= w_word;
                r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
            end

            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_word_count    <= r_word_count + 16'd1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end

            // A drop and a clear in the same cycle leave the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Bench for lfsr_word_packer: queue-based reference model of packing, FIFO,
// enable throttling and overflow, plus a behavioural 16-bit Galois LFSR source.
module tb_lfsr_word_packer;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned NBITS = 2200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        lfsr_enable;
    logic [0:0]  lfsr_bits;
    logic        lfsr_valid;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_level;
    logic [15:0] word_count;
    logic        overflow;
    logic        clear_overflow;

    always #5 clk = ~clk;

    lfsr_word_packer #(.IN_BITS(1), .WORD_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .lfsr_enable    (lfsr_enable),
        .lfsr_bits      (lfsr_bits),
        .lfsr_valid     (lfsr_valid),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .fifo_level     (fifo_level),
        .word_count     (word_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         pend[$];
    int         exp_count;
    bit         exp_ovf;
    bit         exp_run_q;

    bit ref_bits [NBITS];
    bit en_prev;
    int gen_idx;
    int rx_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        exp_count = 0;
        exp_ovf   = 1'b0;
        exp_run_q = 1'b0;
        en_prev   = 1'b0;
    endtask

    // Predict the effect of the upcoming rising edge from the current inputs
    task automatic model_edge();
        bit         pop;
        bit         full;
        bit         set_ovf;
        logic [7:0] w;
        full    = (exp_q.size() == int'(D));
        pop     = (exp_q.size() != 0) && word_ready;
        set_ovf = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (lfsr_valid) begin
            pend.push_back(lfsr_bits[0]);
            if (pend.size() == int'(W)) begin
                w = '0;
                for (int i = 0; i < int'(W); i++) w[i] = pend[i];
                pend.delete();
                if (!full || pop) begin
                    exp_q.push_back(w);
                    exp_count = (exp_count + 1) & 16'hFFFF;
                end else begin
                    set_ovf = 1'b1;
                end
            end
        end
        if (set_ovf) exp_ovf = 1'b1;
        else if (clear_overflow) exp_ovf = 1'b0;
        exp_run_q = run;
    endtask

    task automatic check_all();
        int free_n;
        free_n = int'(D) - exp_q.size();
        chk("enable", 32'(lfsr_enable), 32'(exp_run_q && (free_n >= 2)));
        chk("valid",  32'(word_valid),  32'(exp_q.size() != 0));
        chk("level",  32'(fifo_level),  32'(exp_q.size()));
        if (exp_q.size() != 0) chk("data", 32'(word_data), 32'(exp_q[0]));
        chk("count",  32'(word_count),  32'(exp_count));
        chk("ovf",    32'(overflow),    32'(exp_ovf));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input bit b);
        lfsr_valid = v;
        lfsr_bits  = b;
    endtask

    // One cycle of a 1-cycle-latency LFSR obeying lfsr_enable
    task automatic lfsr_cycle(input bit use_ref);
        lfsr_valid = en_prev;
        if (en_prev) begin
            if (use_ref && gen_idx < int'(NBITS)) begin
                lfsr_bits = ref_bits[gen_idx];
                gen_idx++;
            end else begin
                lfsr_bits = 1'($urandom);
            end
        end
        en_prev = lfsr_enable;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_data", 32'(word_data), 32'h0);
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        bit         chunks[8];
        bit         pat[8];
        int         cnt0;
        int         cycles;
        logic [15:0] s;
        logic [7:0] e;

        reset_n        = 1'b1;
        run            = 1'b1;
        lfsr_valid     = 1'b0;
        lfsr_bits      = 1'b0;
        word_ready     = 1'b0;
        clear_overflow = 1'b0;
        gen_idx        = 0;
        rx_idx         = 0;
        model_reset();

        // Reset with run held high; enable appears only after run_q fills
        @(negedge clk);
        do_reset();
        tick();
        chk("rst_en_after", 32'(lfsr_enable), 32'h1);
        run = 1'b0;
        tick();

        // Bit order: first chunk lands in the LSB
        chunks = '{1, 0, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, chunks[i]);
            tick();
        end
        chk("bitorder_data",  32'(word_data),  32'h0D);
        chk("bitorder_count", 32'(word_count), 32'h1);
        drive(1'b0, 1'b0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Backpressure: enable throttles once only one entry is free
        run = 1'b1;
        en_prev = 1'b0;
        repeat (60) lfsr_cycle(1'b0);
        chk("bp_level",  32'(fifo_level),  32'h3);
        chk("bp_enable", 32'(lfsr_enable), 32'h0);
        chk("bp_ovf",    32'(overflow),    32'h0);
        word_ready = 1'b1;
        repeat (60) lfsr_cycle(1'b0);
        run = 1'b0;
        repeat (3) lfsr_cycle(1'b0);
        while (pend.size() != 0) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0);
        repeat (3) tick();
        chk("drain_level", 32'(fifo_level), 32'h0);

        // Pause mid-word: partial word survives run deasserting
        word_ready = 1'b0;
        cnt0 = exp_count;
        pat = '{1, 1, 0, 0, 1, 0, 1, 0};
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat[i]);
            tick();
        end
        run = 1'b0;
        drive(1'b0, 1'b0);
        repeat (10) tick();
        chk("pause_nocount", 32'(word_count), 32'(cnt0));
        run = 1'b1;
        for (int i = 3; i < 8; i++) begin
            drive(1'b1, pat[i]);
            tick();
        end
        run = 1'b0;
        drive(1'b0, 1'b0);
        tick();
        chk("pause_data",  32'(word_data),  32'h53);
        chk("pause_count", 32'(word_count), 32'((cnt0 + 1) & 16'hFFFF));
        chk("pause_level", 32'(fifo_level), 32'h1);

        // Overflow: forced chunks past a full FIFO
        repeat (24) begin
            drive(1'b1, 1'($urandom));
            tick();
        end
        chk("full_level", 32'(fifo_level), 32'h4);
        cnt0 = exp_count;
        repeat (8) begin
            drive(1'b1, 1'($urandom));
            tick();
        end
        chk("ovf_set",   32'(overflow),   32'h1);
        chk("ovf_level", 32'(fifo_level), 32'h4);
        chk("ovf_count", 32'(word_count), 32'(cnt0));
        drive(1'b0, 1'b0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'h0);

        // Push into a full FIFO alongside a pop is legal
        repeat (7) begin
            drive(1'b1, 1'($urandom));
            tick();
        end
        drive(1'b1, 1'($urandom));
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("fullpop_ovf",   32'(overflow),   32'h0);
        chk("fullpop_level", 32'(fifo_level), 32'h4);

        // Set and clear in the same cycle: set wins
        repeat (7) begin
            drive(1'b1, 1'($urandom));
            tick();
        end
        drive(1'b1, 1'($urandom));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        drive(1'b0, 1'b0);
        chk("setwins", 32'(overflow), 32'h1);

        // Asynchronous reset while full and mid-word
        drive(1'b1, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("async_level", 32'(fifo_level), 32'h0);
        chk("async_valid", 32'(word_valid), 32'h0);
        drive(1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        // Integration with a Galois LFSR (x^16+x^14+x^13+x^11+1), seed 1
        s = 16'h0001;
        for (int i = 0; i < int'(NBITS); i++) begin
            ref_bits[i] = s[0];
            s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end
        run     = 1'b1;
        en_prev = 1'b0;
        gen_idx = 0;
        rx_idx  = 0;
        cycles  = 0;
        while (rx_idx < 256 && cycles < 20000) begin
            word_ready = 1'($urandom_range(0, 1));
            if (gen_idx >= 2048) run = 1'b0;
            if (word_valid && word_ready) begin
                for (int i = 0; i < 8; i++) e[i] = ref_bits[rx_idx * 8 + i];
                chk("stream_word", 32'(word_data), 32'(e));
                rx_idx++;
            end
            lfsr_cycle(1'b1);
            cycles++;
        end
        chk("stream_words", 32'(rx_idx), 32'd256);
        run        = 1'b0;
        word_ready = 1'b0;
        repeat (4) lfsr_cycle(1'b1);
        chk("stream_count", 32'(word_count), 32'd256);
        chk("stream_ovf",   32'(overflow),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
